// File: rtl/icache_pkg.sv
// Shared constants, state encoding and address-field helpers for the
// I-cache refill controller.
package icache_pkg;

    localparam int TAG_W      = 20;
    localparam int INDEX_W    = 7;
    localparam int OFFSET_W   = 5;
    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 32;
    localparam int SEL_W      = 3;
    localparam int LINE_W     = LINE_WORDS * WORD_W;

    localparam logic [7:0] ARLEN_LINE   = 8'd7;
    localparam logic [2:0] ARSIZE_WORD  = 3'd2;
    localparam logic [1:0] ARBURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MISS   = 3'd2,
        REFILL = 3'd3,
        RESP   = 3'd4
    } state_t;

    function automatic logic [SEL_W-1:0] word_off(input logic [31:0] a);
        return a[OFFSET_W-1:2];
    endfunction

    function automatic logic [INDEX_W-1:0] set_index(input logic [31:0] a);
        return a[OFFSET_W+INDEX_W-1:OFFSET_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31:32-TAG_W];
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bundle of CPU, tag RAM, data RAM and AXI read signals around the refill
// controller. master = controller side, slave = everything around it.
// Handshakes: a transfer happens on a clock edge where valid (or req) and
// ready (or addr_ok) are both high; the valid side holds its payload stable
// until that edge and never waits on ready before asserting valid.
interface icache_refill_ctrl_if;

    logic                                   cpu_req;
    logic [31:0]                            cpu_addr;
    logic                                   cpu_addr_ok;
    logic                                   cpu_data_ok;
    logic [31:0]                            cpu_rdata;

    logic                                   tag_en;
    logic [3:0]                             tag_wen;
    logic [icache_pkg::TAG_W:0]             tag_wdata;
    logic [31:0]                            tag_addr;
    logic                                   tag_hit;
    logic                                   tag_valid;

    logic                                   data_en;
    logic [icache_pkg::LINE_WORDS-1:0]      data_wen;
    logic [icache_pkg::INDEX_W-1:0]         data_index;
    logic [31:0]                            data_wdata;
    logic [icache_pkg::LINE_W-1:0]          data_rdata;

    logic                                   arvalid;
    logic                                   arready;
    logic [31:0]                            araddr;
    logic [7:0]                             arlen;
    logic [2:0]                             arsize;
    logic [1:0]                             arburst;
    logic                                   rvalid;
    logic                                   rready;
    logic [31:0]                            rdata;
    logic                                   rlast;

    modport master (
        input  cpu_req, cpu_addr, tag_hit, tag_valid, data_rdata,
               arready, rvalid, rdata, rlast,
        output cpu_addr_ok, cpu_data_ok, cpu_rdata,
               tag_en, tag_wen, tag_wdata, tag_addr,
               data_en, data_wen, data_index, data_wdata,
               arvalid, araddr, arlen, arsize, arburst, rready
    );

    modport slave (
        output cpu_req, cpu_addr, tag_hit, tag_valid, data_rdata,
               arready, rvalid, rdata, rlast,
        input  cpu_addr_ok, cpu_data_ok, cpu_rdata,
               tag_en, tag_wen, tag_wdata, tag_addr,
               data_en, data_wen, data_index, data_wdata,
               arvalid, araddr, arlen, arsize, arburst, rready
    );

endinterface

// File: rtl/icache_word_sel.sv
// Picks one 32-bit word out of the eight data-bank outputs.
module icache_word_sel
    import icache_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [SEL_W-1:0]  sel,
    output logic [WORD_W-1:0] word
);

    // Bank k sits at bits [32k+31:32k]
    always_comb begin
        word = line[sel*WORD_W +: WORD_W];
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Single-request I-cache control: lookup, AXI line refill on miss, tag
// write at end of line, then word return to the CPU.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    icache_refill_ctrl_if.master bus,
    output state_t               dbg_state
);

    state_t             state_q, state_d;
    logic [31:0]        req_addr_q;
    logic [SEL_W-1:0]   cnt_q;
    logic [WORD_W-1:0]  word_q;
    logic [WORD_W-1:0]  hit_word;

    assign dbg_state = state_q;

    icache_word_sel u_word_sel (
        .line (bus.data_rdata),
        .sel  (word_off(req_addr_q)),
        .word (hit_word)
    );

    // State, request address, beat counter and critical-word buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.cpu_req) begin
                req_addr_q <= bus.cpu_addr;
            end
            if (state_q == MISS && bus.arready) begin
                cnt_q <= '0;
            end
            if (state_q == REFILL && bus.rvalid) begin
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == word_off(req_addr_q)) begin
                    word_q <= bus.rdata;
                end
            end
        end
    end

    // Next state and all outputs; everything idles low while in reset
    always_comb begin
        state_d         = state_q;
        bus.cpu_addr_ok = 1'b0;
        bus.cpu_data_ok = 1'b0;
        bus.cpu_rdata   = '0;
        bus.tag_en      = 1'b0;
        bus.tag_wen     = 4'h0;
        bus.tag_wdata   = '0;
        bus.tag_addr    = '0;
        bus.data_en     = 1'b0;
        bus.data_wen    = '0;
        bus.data_index  = '0;
        bus.data_wdata  = '0;
        bus.arvalid     = 1'b0;
        bus.araddr      = '0;
        bus.arlen       = ARLEN_LINE;
        bus.arsize      = ARSIZE_WORD;
        bus.arburst     = ARBURST_INCR;
        bus.rready      = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    bus.cpu_addr_ok = bus.cpu_req;
                    if (bus.cpu_req) begin
                        bus.tag_en     = 1'b1;
                        bus.data_en    = 1'b1;
                        bus.tag_addr   = bus.cpu_addr;
                        bus.data_index = set_index(bus.cpu_addr);
                        state_d        = LOOKUP;
                    end
                end
                LOOKUP: begin
                    bus.tag_addr   = req_addr_q;
                    bus.data_index = set_index(req_addr_q);
                    // A matching tag with valid=0 is still a miss
                    if (bus.tag_hit && bus.tag_valid) begin
                        bus.cpu_data_ok = 1'b1;
                        bus.cpu_rdata   = hit_word;
                        state_d         = IDLE;
                    end else begin
                        state_d = MISS;
                    end
                end
                MISS: begin
                    bus.arvalid = 1'b1;
                    bus.araddr  = {req_addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
                    if (bus.arready) begin
                        state_d = REFILL;
                    end
                end
                REFILL: begin
                    bus.rready = 1'b1;
                    if (bus.rvalid) begin
                        bus.data_en    = 1'b1;
                        bus.data_wen   = LINE_WORDS'(1) << cnt_q;
                        bus.data_index = set_index(req_addr_q);
                        bus.data_wdata = bus.rdata;
                        // rlast ends the refill even if the line is short
                        if (bus.rlast) begin
                            bus.tag_en    = 1'b1;
                            bus.tag_wen   = 4'hF;
                            bus.tag_wdata = {1'b1, addr_tag(req_addr_q)};
                            bus.tag_addr  = req_addr_q;
                            state_d       = RESP;
                        end
                    end
                end
                RESP: begin
                    bus.cpu_data_ok = 1'b1;
                    bus.cpu_rdata   = word_q;
                    state_d         = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: lookup vector table, hand-written refill
// sequences, and randomized fetches against a transparent-cache model.
module tb_icache_refill_ctrl;
    import icache_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    icache_refill_ctrl_if intf ();

    icache_refill_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (intf),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Directly driven RAM-side values, or a behavioural RAM model
    logic              ram_on    = 1'b0;
    logic              ram_clear = 1'b0;
    logic              d_hit     = 1'b0;
    logic              d_valid   = 1'b0;
    logic [LINE_W-1:0] d_line    = '0;

    logic [TAG_W:0]    tag_mem  [128];
    logic [LINE_W-1:0] data_mem [128];
    logic [TAG_W:0]    rd_tag   = '0;
    logic [TAG_W-1:0]  rd_cmp   = '0;
    logic [LINE_W-1:0] rd_line  = '0;

    assign intf.tag_hit    = ram_on ? (rd_tag[TAG_W-1:0] == rd_cmp) : d_hit;
    assign intf.tag_valid  = ram_on ? rd_tag[TAG_W] : d_valid;
    assign intf.data_rdata = ram_on ? rd_line : d_line;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 128; i++) tag_mem[i] <= '0;
        end else if (ram_on) begin
            if (intf.tag_en) begin
                if (intf.tag_wen != 4'h0) tag_mem[intf.tag_addr[11:5]] <= intf.tag_wdata;
                else begin
                    rd_tag <= tag_mem[intf.tag_addr[11:5]];
                    rd_cmp <= intf.tag_addr[31:12];
                end
            end
            if (intf.data_en) begin
                if (intf.data_wen == '0) rd_line <= data_mem[intf.data_index];
                for (int k = 0; k < LINE_WORDS; k++)
                    if (intf.data_wen[k]) data_mem[intf.data_index][k*32 +: 32] <= intf.data_wdata;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        intf.cpu_req  = 1'b0;
        intf.cpu_addr = '0;
        intf.arready  = 1'b0;
        intf.rvalid   = 1'b0;
        intf.rdata    = '0;
        intf.rlast    = 1'b0;
        d_hit   = 1'b0;
        d_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [LINE_W-1:0] make_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_WORDS; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    // Backing memory contents: any fixed, address-dependent pattern
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic        valid;
        logic [31:0] base;
        logic        exp_ok;
        logic [31:0] exp_rdata;
        logic [6:0]  exp_index;
        logic [31:0] exp_araddr;
    } vec_t;

    vec_t vecs[7];

    // Drive one beat of a directed refill and check its bank write
    task automatic beat(input int b, input logic [31:0] d, input logic last, input logic [6:0] idx);
        intf.rvalid = 1'b1;
        intf.rdata  = d;
        intf.rlast  = last;
        #1;
        chk("beat_rready", intf.rready, 1'b1);
        chk("beat_wen", intf.data_wen, 8'(1) << b);
        chk("beat_index", intf.data_index, idx);
        chk("beat_wdata", intf.data_wdata, d);
        chk("beat_tag_en", intf.tag_en, last);
        tick();
        intf.rvalid = 1'b0;
        intf.rlast  = 1'b0;
    endtask

    logic [31:0] a_exp_line;
    int          writes;
    logic        mv [128];
    logic [19:0] mt [128];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        // Reset state while rst is held
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        chk("rst_addr_ok", intf.cpu_addr_ok, 0);
        chk("rst_data_ok", intf.cpu_data_ok, 0);
        chk("rst_arvalid", intf.arvalid, 0);
        chk("rst_rready", intf.rready, 0);
        chk("rst_tag_en", intf.tag_en, 0);
        chk("rst_data_wen", intf.data_wen, 0);
        chk("rst_arlen", intf.arlen, 8'd7);
        chk("rst_arsize", intf.arsize, 3'd2);
        chk("rst_arburst", intf.arburst, 2'b01);
        rst = 1'b0;

        // ---------------- lookup table ----------------
        vecs[0] = '{32'h0000_1234, 1, 1, 32'hDEAD_BEEA, 1, 32'hDEAD_BEEF, 7'h11, 32'h0};
        vecs[1] = '{32'h0000_0000, 1, 1, 32'h1111_0000, 1, 32'h1111_0000, 7'h00, 32'h0};
        vecs[2] = '{32'h8000_0FFC, 1, 1, 32'h2222_0000, 1, 32'h2222_0007, 7'h7F, 32'h0};
        vecs[3] = '{32'h0000_1234, 1, 0, 32'h3333_0000, 0, 32'h0, 7'h11, 32'h0000_1220};
        vecs[4] = '{32'h1FC0_0024, 0, 1, 32'h4444_0000, 0, 32'h0, 7'h01, 32'h1FC0_0020};
        vecs[5] = '{32'h7654_3210, 0, 0, 32'h5555_0000, 0, 32'h0, 7'h10, 32'h7654_3200};
        vecs[6] = '{32'h0000_0048, 1, 1, 32'hA5A5_0000, 1, 32'hA5A5_0002, 7'h02, 32'h0};
        for (int i = 0; i < 7; i++) begin
            intf.cpu_req  = 1'b1;
            intf.cpu_addr = vecs[i].addr;
            #1;
            chk("acc_addr_ok", intf.cpu_addr_ok, 1);
            chk("acc_tag_en", intf.tag_en, 1);
            chk("acc_data_en", intf.data_en, 1);
            chk("acc_tag_addr", intf.tag_addr, vecs[i].addr);
            chk("acc_index", intf.data_index, vecs[i].exp_index);
            tick();
            intf.cpu_req = 1'b0;
            d_hit   = vecs[i].hit;
            d_valid = vecs[i].valid;
            d_line  = make_line(vecs[i].base);
            #1;
            chk("lk_state", 64'(dbg_state), 64'(LOOKUP));
            chk("lk_index", intf.data_index, vecs[i].exp_index);
            chk("lk_data_ok", intf.cpu_data_ok, vecs[i].exp_ok);
            chk("lk_rdata", intf.cpu_rdata, vecs[i].exp_rdata);
            tick();
            chk("post_arvalid", intf.arvalid, !vecs[i].exp_ok);
            chk("post_araddr", intf.araddr, vecs[i].exp_araddr);
            do_reset();
        end

        // ---------------- cold miss, backpressure, busy ----------------
        intf.cpu_req  = 1'b1;
        intf.cpu_addr = 32'h1FC0_0024;
        #1;
        chk("cm_addr_ok", intf.cpu_addr_ok, 1);
        tick();
        intf.cpu_addr = 32'h0000_2000;
        d_hit   = 1'b1;
        d_valid = 1'b0;
        #1;
        chk("cm_lk_data_ok", intf.cpu_data_ok, 0);
        chk("cm_lk_addr_ok", intf.cpu_addr_ok, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("cm_arvalid", intf.arvalid, 1);
            chk("cm_araddr", intf.araddr, 32'h1FC0_0020);
            chk("cm_arlen", intf.arlen, 8'd7);
            chk("cm_busy", intf.cpu_addr_ok, 0);
            tick();
        end
        intf.arready = 1'b1;
        #1;
        chk("cm_ar_hs", intf.araddr, 32'h1FC0_0020);
        tick();
        intf.arready = 1'b0;
        writes = 0;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) begin
                for (int g = 0; g < 2; g++) begin
                    #1;
                    chk("gap_wen", intf.data_wen, 0);
                    chk("gap_rready", intf.rready, 1);
                    chk("gap_busy", intf.cpu_addr_ok, 0);
                    tick();
                end
            end
            intf.rvalid = 1'b1;
            intf.rdata  = 32'hA0 + 32'(b);
            intf.rlast  = (b == 7);
            #1;
            if (intf.data_wen != 0) writes++;
            chk("cm_busy_beat", intf.cpu_addr_ok, 0);
            if (b == 7) begin
                chk("cm_tag_wen", intf.tag_wen, 4'hF);
                chk("cm_tag_wdata", intf.tag_wdata, 21'h11FC00);
                chk("cm_tag_addr", intf.tag_addr, 32'h1FC0_0024);
            end
            intf.rvalid = 1'b0;
            #0;
            intf.rvalid = 1'b1;
            beat(b, 32'hA0 + 32'(b), b == 7, 7'h01);
        end
        chk("cm_writes", writes, 8);
        #1;
        chk("cm_resp_ok", intf.cpu_data_ok, 1);
        chk("cm_resp_rdata", intf.cpu_rdata, 32'hA1);
        chk("cm_resp_busy", intf.cpu_addr_ok, 0);
        tick();
        #1;
        chk("cm_idle_accept", intf.cpu_addr_ok, 1);
        chk("cm_idle_tag_addr", intf.tag_addr, 32'h0000_2000);
        do_reset();

        // ---------------- reset during refill ----------------
        intf.cpu_req  = 1'b1;
        intf.cpu_addr = 32'h0000_0040;
        tick();
        intf.cpu_req = 1'b0;
        tick();
        intf.arready = 1'b1;
        tick();
        intf.arready = 1'b0;
        for (int b = 0; b < 3; b++) beat(b, 32'hC0 + 32'(b), 1'b0, 7'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rr_state", 64'(dbg_state), 64'(IDLE));
        chk("rr_arvalid", intf.arvalid, 0);
        chk("rr_rready", intf.rready, 0);
        chk("rr_tag_en", intf.tag_en, 0);
        chk("rr_data_ok", intf.cpu_data_ok, 0);
        do_reset();

        // ---------------- early rlast ----------------
        intf.cpu_req  = 1'b1;
        intf.cpu_addr = 32'h0000_0060;
        tick();
        intf.cpu_req = 1'b0;
        tick();
        intf.arready = 1'b1;
        tick();
        intf.arready = 1'b0;
        for (int b = 0; b < 4; b++) beat(b, 32'hB0 + 32'(b), b == 3, 7'h03);
        #1;
        chk("er_resp_ok", intf.cpu_data_ok, 1);
        chk("er_resp_rdata", intf.cpu_rdata, 32'hB0);
        tick();
        chk("er_idle", 64'(dbg_state), 64'(IDLE));
        do_reset();

        // ---------------- randomized fetches vs transparent cache ----------------
        ram_clear = 1'b1;
        tick();
        ram_clear = 1'b0;
        ram_on    = 1'b1;
        for (int i = 0; i < 128; i++) mv[i] = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic [19:0] t;
            logic [6:0]  ix;
            logic [31:0] a;
            logic        exp_miss, got, ar_seen;
            logic [31:0] got_data;
            int          beats, last_cyc, ok_cyc;
            case ($urandom_range(0, 2))
                0: t = 20'h00001;
                1: t = 20'h00ABC;
                default: t = 20'hFFFFF;
            endcase
            case ($urandom_range(0, 2))
                0: ix = 7'h00;
                1: ix = 7'h05;
                default: ix = 7'h7F;
            endcase
            a = {t, ix, 3'($urandom_range(0, 7)), 2'b00};
            exp_miss = !(mv[ix] && mt[ix] == t);
            intf.cpu_req  = 1'b1;
            intf.cpu_addr = a;
            #1;
            chk("rnd_addr_ok", intf.cpu_addr_ok, 1);
            tick();
            intf.cpu_req = 1'b0;
            got = 0; ar_seen = 0; beats = 0; last_cyc = -1; ok_cyc = -1; got_data = '0;
            for (int cyc = 0; cyc < 300 && !got; cyc++) begin
                intf.arready = ($urandom_range(0, 2) == 0);
                intf.rvalid  = (beats < 8) && ($urandom_range(0, 1) == 1);
                intf.rdata   = mem_word({a[31:5], 5'b0} + 32'(beats * 4));
                intf.rlast   = (beats == 7);
                #1;
                if (intf.arvalid && !ar_seen) begin
                    ar_seen = 1;
                    chk("rnd_araddr", intf.araddr, {a[31:5], 5'b0});
                end
                if (intf.rvalid && intf.rready) begin
                    beats++;
                    last_cyc = cyc;
                end
                if (intf.cpu_data_ok) begin
                    got = 1;
                    ok_cyc = cyc;
                    got_data = intf.cpu_rdata;
                end
                tick();
            end
            intf.arready = 1'b0;
            intf.rvalid  = 1'b0;
            intf.rlast   = 1'b0;
            chk("rnd_response", got, 1);
            chk("rnd_rdata", got_data, mem_word(a));
            chk("rnd_ar_issued", ar_seen, exp_miss);
            if (exp_miss) begin
                chk("rnd_beats", beats, 8);
                chk("rnd_miss_latency", ok_cyc, last_cyc + 1);
                mv[ix] = 1'b1;
                mt[ix] = t;
            end else begin
                chk("rnd_hit_latency", ok_cyc, 0);
            end
            if (!got) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Control stage directly downstream of the I-cache tag RAM wrapper.
- Accepts CPU fetch requests, drives tag/data RAM lookups, and consumes the tag wrapper's hit/valid outputs.
- On a miss, fetches the 32-byte line over an AXI4 read burst, writes the data banks and the tag, then returns the requested word.
- Geometry: 128 sets, 8 words per line, 20-bit tag plus 1 valid bit (tag word = {valid, addr[31:12]}).

Parameters:
- TAG_W, 20, tag width, addr[31:12]
- INDEX_W, 7, set index width, addr[11:5]
- LINE_WORDS, 8, 32-bit words per line; word select is addr[4:2]

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  fetch request
- cpu_addr  in  32  fetch address, word aligned
- cpu_addr_ok  out  1  request accepted this cycle
- cpu_data_ok  out  1  cpu_rdata valid this cycle
- cpu_rdata  out  32  fetched instruction
- tag_en  out  1  tag RAM enable
- tag_wen  out  4  tag RAM byte write enables
- tag_wdata  out  21  {valid, tag}
- tag_addr  out  32  address to tag wrapper (index and compare)
- tag_hit  in  1  tag compare result
- tag_valid  in  1  stored valid bit
- data_en  out  1  data RAM enable, all 8 banks
- data_wen  out  8  one-hot bank write enable
- data_index  out  7  data RAM set index
- data_wdata  out  32  refill word
- data_rdata  in  256  8 bank outputs, bank k at [32k+31:32k]
- arvalid / arready  out / in  1 / 1  AXI AR handshake
- araddr  out  32  line-aligned address
- arlen  out  8  burst length
- arsize  out  3  beat size
- arburst  out  2  burst type
- rvalid / rready  in / out  1 / 1  AXI R handshake
- rdata  in  32  beat data
- rlast  in  1  last beat

Behaviour:
- Reset: state IDLE. All outputs are 0 except constant AXI fields: arlen=7, arsize=2, arburst=2'b01 (INCR).
- IDLE:
  - cpu_addr_ok = cpu_req.
  - On accept: latch req_addr <= cpu_addr; assert tag_en and data_en with tag_addr=cpu_addr and data_index=cpu_addr[11:5]; go to LOOKUP.
- LOOKUP: RAM outputs are valid this cycle. tag_addr and data_index are driven from req_addr.
  - tag_hit && tag_valid: cpu_data_ok=1 and cpu_rdata=data_rdata bank req_addr[4:2]; go to IDLE. Hit latency is 1 cycle after accept.
  - Otherwise: go to MISS. A stored valid=0 is a miss even if the tag matches.
- MISS: arvalid=1 and araddr={req_addr[31:5],5'b0}, held stable until arready. On arready, clear beat counter cnt to 0 and go to REFILL.
- REFILL: rready=1. Each beat (rvalid && rready):
  - data_en=1, data_wen=1<<cnt, data_index=req_addr[11:5], data_wdata=rdata.
  - If cnt==req_addr[4:2], latch rdata into the word buffer.
  - cnt increments and wraps modulo 8.
- End of line: on the beat with rlast=1, also assert tag_en=1, tag_wen=4'hF, tag_wdata={1'b1, req_addr[31:12]}, tag_addr=req_addr; go to RESP.
- RESP: cpu_data_ok=1 with cpu_rdata=word buffer; go to IDLE. Miss response is the cycle after the rlast beat.
- Busy: cpu_addr_ok=0 in every state except IDLE. The block holds only one request at a time.
- rvalid gaps: cnt and state hold. Beats are never dropped.
- rlast on a beat other than cnt==7: the refill still ends there; banks not yet written keep stale data. This is a protocol error and is not masked.
- rvalid outside REFILL is ignored; rready=0.
- Reset mid-operation: synchronous return to IDLE on the next edge; arvalid, rready and every write enable drop to 0. Partially written banks are harmless because the tag is not yet written.
- cpu_rdata is 0 when cpu_data_ok=0.

Decomposition:
- Shared package icache_pkg holds:
  - TAG_W, INDEX_W and OFFSET_W=5 constants
  - state enum {IDLE, LOOKUP, MISS, REFILL, RESP}
  - AXI constants: ARLEN_LINE=8'd7, ARSIZE_WORD=3'd2, ARBURST_INCR=2'b01
- Sub-module icache_word_sel: 256-to-32 bank mux indexed by word offset. It is used for the LOOKUP hit path.

Test Plan:
- Cold miss: req addr 0x1FC0_0024, tag_valid=0 → araddr=0x1FC0_0020 with arlen=7; 8 beats 0xA0..0xA7 with rlast on the 8th → data_wen 0x01..0x80 on index 0x01; tag_wdata=0x11FC00; cpu_data_ok with rdata=0xA1 the cycle after rlast.
- Hit: tag_hit=tag_valid=1 and bank 5 of data_rdata = 0xDEADBEEF, req addr 0x0000_1234 → cpu_data_ok one cycle after accept, rdata = word at offset 5.
- Backpressure: arready held low 3 cycles → araddr stable; rvalid gaps of 2 cycles between beats → cnt holds and exactly 8 writes occur.
- Busy: cpu_req held high during REFILL → cpu_addr_ok=0 until IDLE, then accepted on the first IDLE cycle.
- Reset during REFILL after beat 3 → next cycle arvalid=rready=0, no tag write, state IDLE, cpu_data_ok=0.
- Tag match with valid=0 → treated as miss; AR issued.
